// File: rtl/refill_write_packer.sv
// rtl/refill_write_packer.sv - packs a 16-word refill block into four LANES-wide data array writes
module refill_write_packer #(
    parameter int WORD_WIDTH = 20,
    parameter int LANES      = 4,
    parameter int ROWS       = 4,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          i_miss_valid,
    input  logic [TAG_WIDTH-1:0]          i_miss_tag,
    input  logic [3:0]                    i_miss_set,
    input  logic [1:0]                    i_miss_way,
    output logic                          o_miss_ready,
    output logic                          o_mem_req_valid,
    output logic [TAG_WIDTH+3:0]          o_mem_req_addr,
    input  logic                          i_mem_req_ready,
    input  logic                          i_mem_rsp_valid,
    input  logic [WORD_WIDTH-1:0]         i_mem_rsp_data,
    output logic                          o_mem_rsp_ready,
    output logic [3:0]                    o_w_set_bits,
    output logic [1:0]                    o_w_way_index,
    output logic [1:0]                    o_w_block_offset_bits,
    output logic [WORD_WIDTH*LANES-1:0]   o_w_data,
    output logic                          o_w_valid,
    input  logic                          i_w_ready,
    output logic                          o_fill_done,
    output logic                          o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);
    localparam logic [1:0] LAST_ROW  = 2'(ROWS - 1);

    state_t                        r_state;
    state_t                        w_next;
    logic [TAG_WIDTH-1:0]          r_tag;
    logic [3:0]                    r_set;
    logic [1:0]                    r_way;
    logic [1:0]                    r_row;
    logic [1:0]                    r_lane;
    logic [WORD_WIDTH*LANES-1:0]   r_data;

    logic w_miss_acc;
    logic w_rsp_acc;
    logic w_write_acc;

    // Handshakes are qualified by state only, so no ready input reaches another ready output.
    assign w_miss_acc  = (r_state == S_IDLE)    && i_miss_valid;
    assign w_rsp_acc   = (r_state == S_COLLECT) && i_mem_rsp_valid;
    assign w_write_acc = (r_state == S_WRITE)   && i_w_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_miss_valid) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_req_ready) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (i_mem_rsp_valid && (r_lane == LAST_LANE)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_w_ready) begin
                    w_next = (r_row == LAST_ROW) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_tag  <= '0;
            r_set  <= '0;
            r_way  <= '0;
            r_row  <= '0;
            r_lane <= '0;
            r_data <= '0;
        end else begin
            if (w_miss_acc) begin
                r_tag  <= i_miss_tag;
                r_set  <= i_miss_set;
                r_way  <= i_miss_way;
                r_row  <= '0;
                r_lane <= '0;
            end
            if (w_rsp_acc) begin
                r_data[r_lane*WORD_WIDTH +: WORD_WIDTH] <= i_mem_rsp_data;
                r_lane <= (r_lane == LAST_LANE) ? 2'd0 : r_lane + 2'd1;
            end
            // The last row's write leaves the row counter alone; the next miss clears it.
            if (w_write_acc && (r_row != LAST_ROW)) begin
                r_row <= r_row + 2'd1;
            end
        end
    end

    assign o_miss_ready          = (r_state == S_IDLE);
    assign o_busy                = (r_state != S_IDLE);
    assign o_mem_req_valid       = (r_state == S_REQ);
    assign o_mem_req_addr        = {r_tag, r_set};
    assign o_mem_rsp_ready       = (r_state == S_COLLECT);
    assign o_w_valid             = (r_state == S_WRITE);
    assign o_w_set_bits          = r_set;
    assign o_w_way_index         = r_way;
    assign o_w_block_offset_bits = r_row;
    assign o_w_data              = r_data;
    assign o_fill_done           = (r_state == S_DONE);

endmodule

// File: tb/tb_refill_write_packer.sv
// tb/tb_refill_write_packer.sv - randomized block-refill bench against a word-list model
module tb_refill_write_packer;

    localparam int WW = 20;
    localparam int LN = 4;
    localparam int RW = 4;
    localparam int TW = 8;

    logic              clk = 1'b0;
    logic              srst;
    logic              i_miss_valid;
    logic [TW-1:0]     i_miss_tag;
    logic [3:0]        i_miss_set;
    logic [1:0]        i_miss_way;
    logic              o_miss_ready;
    logic              o_mem_req_valid;
    logic [TW+3:0]     o_mem_req_addr;
    logic              i_mem_req_ready;
    logic              i_mem_rsp_valid;
    logic [WW-1:0]     i_mem_rsp_data;
    logic              o_mem_rsp_ready;
    logic [3:0]        o_w_set_bits;
    logic [1:0]        o_w_way_index;
    logic [1:0]        o_w_block_offset_bits;
    logic [WW*LN-1:0]  o_w_data;
    logic              o_w_valid;
    logic              i_w_ready;
    logic              o_fill_done;
    logic              o_busy;

    int n_checks = 0;
    int n_fails  = 0;

    logic [TW-1:0] nx_tag;
    logic [3:0]    nx_set;
    logic [1:0]    nx_way;

    refill_write_packer #(
        .WORD_WIDTH(WW), .LANES(LN), .ROWS(RW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .srst(srst),
        .i_miss_valid(i_miss_valid), .i_miss_tag(i_miss_tag),
        .i_miss_set(i_miss_set), .i_miss_way(i_miss_way),
        .o_miss_ready(o_miss_ready),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
        .i_mem_req_ready(i_mem_req_ready),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
        .o_mem_rsp_ready(o_mem_rsp_ready),
        .o_w_set_bits(o_w_set_bits), .o_w_way_index(o_w_way_index),
        .o_w_block_offset_bits(o_w_block_offset_bits),
        .o_w_data(o_w_data), .o_w_valid(o_w_valid), .i_w_ready(i_w_ready),
        .o_fill_done(o_fill_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one refill from the caller's negedge. rsp_pct < 0 toggles response valid every other cycle.
    task automatic run_refill(input logic [TW-1:0] tag, input logic [3:0] set, input logic [1:0] way,
                              input bit seq, input int rsp_pct, input int wr_pct, input int req_delay,
                              input int stall_row, input int abort_at, input bit hold_next);
        logic [WW-1:0]    words [16];
        logic [WW*LN-1:0] exp_row;
        int  acc = 0;
        int  writes = 0;
        int  cyc = 0;
        int  delay_cnt = 0;
        int  stall = 0;
        bit  req_done = 0;
        bit  finished = 0;
        for (int k = 0; k < 16; k++) begin
            words[k] = seq ? WW'(k) : WW'($urandom);
        end
        i_miss_valid = 1'b1;
        i_miss_tag   = tag;
        i_miss_set   = set;
        i_miss_way   = way;
        while (!o_miss_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("miss_ready_idle", 128'(o_miss_ready), 128'(1));
        cyc = 0;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (abort_at > 0 && acc == abort_at && o_mem_rsp_ready) begin
                srst = 1'b1;
                i_miss_valid = 1'b0;
                i_mem_rsp_valid = 1'b0;
                i_mem_req_ready = 1'b0;
                i_w_ready = 1'b1;
                @(negedge clk);
                srst = 1'b0;
                check("abort_busy", 128'(o_busy), 128'(0));
                check("abort_miss_ready", 128'(o_miss_ready), 128'(1));
                check("abort_w_data", 128'(o_w_data), 128'(0));
                check("abort_rsp_ready", 128'(o_mem_rsp_ready), 128'(0));
                for (int c = 0; c < 8; c++) begin
                    check("abort_no_write", 128'(o_w_valid | o_fill_done), 128'(0));
                    @(negedge clk);
                end
                return;
            end
            i_miss_valid = hold_next;
            if (hold_next) begin
                i_miss_tag = nx_tag;
                i_miss_set = nx_set;
                i_miss_way = nx_way;
            end
            check("busy", 128'(o_busy), 128'(1));
            check("miss_held_off", 128'(o_miss_ready), 128'(0));
            if (o_mem_req_valid) begin
                check("req_addr", 128'(o_mem_req_addr), 128'({tag, set}));
            end
            if (!req_done) begin
                i_mem_rsp_valid = 1'($urandom_range(0, 1));
                i_mem_rsp_data  = WW'($urandom);
                check("no_rsp_ready_before_collect", 128'(o_mem_rsp_ready), 128'(0));
                i_mem_req_ready = (delay_cnt >= req_delay) ? 1'b1 : 1'b0;
                delay_cnt++;
                if (o_mem_req_valid && i_mem_req_ready) begin
                    req_done = 1;
                end
            end else begin
                i_mem_req_ready = 1'($urandom_range(0, 1));
                if (acc < 16) begin
                    i_mem_rsp_valid = (rsp_pct < 0) ? 1'(cyc % 2) : 1'($urandom_range(0, 99) < rsp_pct);
                    i_mem_rsp_data  = words[acc];
                end else begin
                    i_mem_rsp_valid = 1'b0;
                end
                if (o_mem_rsp_ready && i_mem_rsp_valid) begin
                    acc++;
                end
            end
            if (o_w_valid) begin
                check("rsp_ready_in_write", 128'(o_mem_rsp_ready), 128'(0));
                for (int l = 0; l < LN; l++) begin
                    exp_row[l*WW +: WW] = words[(4*writes + l) % 16];
                end
                check("w_data", 128'(o_w_data), 128'(exp_row));
                check("w_offset", 128'(o_w_block_offset_bits), 128'(writes));
                check("w_set", 128'(o_w_set_bits), 128'(set));
                check("w_way", 128'(o_w_way_index), 128'(way));
                if (stall_row == writes && stall < 5) begin
                    i_w_ready = 1'b0;
                    stall++;
                end else begin
                    i_w_ready = 1'($urandom_range(0, 99) < wr_pct);
                end
                if (i_w_ready) begin
                    writes++;
                end
            end else begin
                i_w_ready = 1'($urandom_range(0, 1));
            end
            if (o_fill_done) begin
                check("done_writes", 128'(writes), 128'(4));
                check("done_words", 128'(acc), 128'(16));
                finished = 1;
            end
        end
        if (!finished) begin
            check("refill_timeout", 128'(0), 128'(1));
            return;
        end
        @(negedge clk);
        if (!hold_next) begin
            i_miss_valid = 1'b0;
        end
        check("done_one_cycle", 128'(o_fill_done), 128'(0));
        check("idle_after_done", 128'(o_busy), 128'(0));
        check("ready_after_done", 128'(o_miss_ready), 128'(1));
    endtask

    initial begin
        srst = 1'b1;
        i_miss_valid = 1'b0;
        i_miss_tag = '0;
        i_miss_set = '0;
        i_miss_way = '0;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data = '0;
        i_w_ready = 1'b0;
        nx_tag = '0;
        nx_set = '0;
        nx_way = '0;
        repeat (2) @(negedge clk);
        check("rst_miss_ready", 128'(o_miss_ready), 128'(1));
        check("rst_busy", 128'(o_busy), 128'(0));
        check("rst_w_valid", 128'(o_w_valid), 128'(0));
        check("rst_req_valid", 128'(o_mem_req_valid), 128'(0));
        check("rst_rsp_ready", 128'(o_mem_rsp_ready), 128'(0));
        check("rst_fill_done", 128'(o_fill_done), 128'(0));
        check("rst_w_data", 128'(o_w_data), 128'(0));
        check("rst_addr", 128'(o_mem_req_addr), 128'(0));
        srst = 1'b0;
        @(negedge clk);

        run_refill(8'h5A, 4'h3, 2'd2, 1, 100, 100, 0, -1, 0, 0);
        run_refill(8'hC1, 4'h9, 2'd1, 0, 100, 100, 0, 1, 0, 0);
        run_refill(8'h5A, 4'h3, 2'd2, 1, -1, 100, 0, -1, 0, 0);
        nx_tag = 8'h77;
        nx_set = 4'hE;
        nx_way = 2'd3;
        run_refill(8'h12, 4'h4, 2'd0, 0, 70, 70, 2, -1, 0, 1);
        run_refill(nx_tag, nx_set, nx_way, 0, 100, 100, 0, -1, 0, 0);
        run_refill(8'h3C, 4'h2, 2'd1, 0, 100, 100, 0, -1, 6, 0);
        run_refill(8'hA5, 4'h5, 2'd3, 0, 100, 100, 0, -1, 0, 0);
        run_refill(8'h0F, 4'hB, 2'd2, 0, 60, 100, 10, -1, 0, 0);
        for (int t = 0; t < 6; t++) begin
            run_refill(TW'($urandom), 4'($urandom), 2'($urandom), 0,
                       $urandom_range(30, 100), $urandom_range(30, 100),
                       $urandom_range(0, 6), $urandom_range(0, 4) - 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
